// File: rtl/host_bridge_pkg.sv
// Shared types and defaults for the host-to-SoC register bridge.
package host_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACK_A  = 3'd1,
        WAIT_D = 3'd2,
        BUS    = 3'd3,
        ACK_F  = 3'd4
    } state_e;

    localparam int unsigned TIMEOUT_DEFAULT  = 64;
    localparam logic [7:0]  ERR_DATA_DEFAULT = 8'hFF;

    // States in which the host sees an acknowledge.
    function automatic logic state_acks(input state_e st);
        return (st == ACK_A) || (st == ACK_F);
    endfunction

endpackage

// File: rtl/host_bridge_sync.sv
// Two-flop synchronizer, one independent chain per bit, cleared by reset.
module host_bridge_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        always_ff @(posedge clk) begin
            if (rst) begin
                meta_q[gi] <= 1'b0;
                sync_q[gi] <= 1'b0;
            end else begin
                meta_q[gi] <= d_i[gi];
                sync_q[gi] <= meta_q[gi];
            end
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/host_bridge.sv
// Responder for the host 4-phase req/ack byte protocol; turns each host
// transaction into one valid/ready access on the SoC register bus.
module host_bridge
    import host_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT,
    parameter logic [7:0]  ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_data,
    output logic       host_ack,
    output logic [7:0] host_rdata,
    output logic       bus_valid,
    output logic       bus_we,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic       bus_ready,
    input  logic [7:0] bus_rdata,
    input  logic       clr_err,
    output logic       err,
    output logic       busy
);

    localparam int unsigned    CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q;
    logic             ack_q;
    logic [7:0]       rdata_q;
    logic             valid_q;
    logic             we_q;
    logic [7:0]       addr_q;
    logic [7:0]       wdata_q;
    logic             err_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;

    logic req_s;
    logic timeout_hit;

    host_bridge_sync #(
        .WIDTH (1)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d_i (host_req),
        .q_o (req_s)
    );

    // A ready in the last counted cycle completes the access normally.
    assign timeout_hit = (state_q == BUS) && !bus_ready && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            rdata_q <= 8'h00;
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (timeout_hit) begin
                err_q <= 1'b1;
            end else if (clr_err) begin
                err_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (req_s) begin
                        addr_q <= host_data;
                        we_q   <= host_we;
                        busy_q <= 1'b1;
                        if (host_we) begin
                            state_q <= ACK_A;
                            ack_q   <= state_acks(ACK_A);
                        end else begin
                            state_q <= BUS;
                            valid_q <= 1'b1;
                            cnt_q   <= '0;
                        end
                    end
                end
                ACK_A: begin
                    if (!req_s) begin
                        state_q <= WAIT_D;
                        ack_q   <= state_acks(WAIT_D);
                    end
                end
                WAIT_D: begin
                    if (req_s) begin
                        wdata_q <= host_data;
                        state_q <= BUS;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                BUS: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus_ready || timeout_hit) begin
                        if (!we_q) begin
                            rdata_q <= bus_ready ? bus_rdata : ERR_DATA;
                        end
                        state_q <= ACK_F;
                        valid_q <= 1'b0;
                        ack_q   <= state_acks(ACK_F);
                    end
                end
                ACK_F: begin
                    if (!req_s) begin
                        state_q <= IDLE;
                        ack_q   <= state_acks(IDLE);
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign host_ack   = ack_q;
    assign host_rdata = rdata_q;
    assign bus_valid  = valid_q;
    assign bus_we     = we_q;
    assign bus_addr   = addr_q;
    assign bus_wdata  = wdata_q;
    assign err        = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_host_bridge.sv
// Directed bench for host_bridge: host handshake driver plus a small bus memory model.
module tb_host_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_req = 1'b0;
    logic       host_we = 1'b0;
    logic [7:0] host_data = 8'h00;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic       bus_valid;
    logic       bus_we;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_ready = 1'b0;
    logic [7:0] bus_rdata = 8'h00;
    logic       clr_err = 1'b0;
    logic       err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    host_bridge #(
        .TIMEOUT  (64),
        .ERR_DATA (8'hFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_data  (host_data),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .bus_valid  (bus_valid),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ready  (bus_ready),
        .bus_rdata  (bus_rdata),
        .clr_err    (clr_err),
        .err        (err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Bus model: unwritten locations read as addr+0x28; ready is raised in
    // BUS cycle index ready_delay (negative = never).
    bit [7:0] mem [256];
    bit       written [256];
    int       ready_delay = 0;
    int       valid_cyc = 0;
    int       valid_total = 0;
    int       wr_cnt = 0;

    always @(negedge clk) begin
        if (bus_valid) begin
            if (ready_delay >= 0 && valid_cyc == ready_delay) begin
                bus_ready = 1'b1;
                bus_rdata = written[bus_addr] ? mem[bus_addr] : bus_addr + 8'h28;
                if (bus_we) begin
                    mem[bus_addr]     = bus_wdata;
                    written[bus_addr] = 1'b1;
                    wr_cnt++;
                end
            end else begin
                bus_ready = 1'b0;
            end
            valid_cyc++;
            valid_total++;
        end else begin
            bus_ready = 1'b0;
            valid_cyc = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic host_req_phase(input logic we, input logic [7:0] data, output int cyc);
        host_we   = we;
        host_data = data;
        host_req  = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!host_ack && cyc < 300);
        if (!host_ack) check("ack_rise_bound", host_ack, 1);
    endtask

    task automatic host_release(output int cyc);
        host_req = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (host_ack && cyc < 300);
        if (host_ack) check("ack_fall_bound", host_ack, 0);
    endtask

    initial begin
        int cyc;
        int v0;
        int w0;

        repeat (3) @(negedge clk);
        check("rst_ack", host_ack, 0);
        check("rst_rdata", host_rdata, 0);
        check("rst_valid", bus_valid, 0);
        check("rst_we", bus_we, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_wdata", bus_wdata, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Write 12 <- A5, bus ready immediately
        ready_delay = 0;
        w0 = wr_cnt;
        host_req_phase(1'b1, 8'h12, cyc);
        check("wr_addr_lat", cyc, 3);
        check("wr_addr_busy", busy, 1);
        host_release(cyc);
        check("wr_addr_rel", cyc, 3);
        host_req_phase(1'b1, 8'hA5, cyc);
        check("wr_data_lat", cyc, 4);
        check("wr_count", wr_cnt - w0, 1);
        check("wr_bus_addr", bus_addr, 8'h12);
        check("wr_bus_we", bus_we, 1);
        check("wr_bus_wdata", bus_wdata, 8'hA5);
        check("wr_err", err, 0);
        host_release(cyc);
        check("wr_mem", mem[8'h12], 8'hA5);
        check("wr_busy_idle", busy, 0);
        $display("txn write addr=12 data=A5 wr_cnt=%0d", wr_cnt - w0);

        // Read 34 with three wait cycles
        ready_delay = 3;
        v0 = valid_total;
        host_req_phase(1'b0, 8'h34, cyc);
        check("rd_lat", cyc, 7);
        check("rd_rdata", host_rdata, 8'h5C);
        check("rd_valid_cycles", valid_total - v0, 4);
        host_release(cyc);
        check("rd_rel", cyc, 3);
        check("rd_rdata_held", host_rdata, 8'h5C);
        $display("txn read addr=34 rdata=%02h", host_rdata);

        // Read 40 with no ready: timeout
        ready_delay = -1;
        v0 = valid_total;
        host_req_phase(1'b0, 8'h40, cyc);
        check("to_lat", cyc, 67);
        check("to_valid_cycles", valid_total - v0, 64);
        check("to_rdata", host_rdata, 8'hFF);
        check("to_err", err, 1);
        host_release(cyc);
        check("to_err_sticky", err, 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("to_err_clr", err, 0);
        $display("txn read-timeout addr=40 rdata=%02h", host_rdata);

        // Ready in the last BUS cycle beats the timeout
        ready_delay = 63;
        v0 = valid_total;
        host_req_phase(1'b0, 8'h50, cyc);
        check("col_lat", cyc, 67);
        check("col_valid_cycles", valid_total - v0, 64);
        check("col_rdata", host_rdata, 8'h78);
        check("col_err", err, 0);
        host_release(cyc);
        $display("txn read-collision addr=50 rdata=%02h", host_rdata);

        // Reset during the BUS phase of a write
        ready_delay = -1;
        w0 = wr_cnt;
        host_req_phase(1'b1, 8'h60, cyc);
        host_release(cyc);
        host_data = 8'h61;
        host_req  = 1'b1;
        cyc = 0;
        while (!bus_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("mrst_in_bus", bus_valid, 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        host_req = 1'b0;
        @(negedge clk);
        check("mrst_ack", host_ack, 0);
        check("mrst_rdata", host_rdata, 0);
        check("mrst_valid", bus_valid, 0);
        check("mrst_we", bus_we, 0);
        check("mrst_addr", bus_addr, 0);
        check("mrst_wdata", bus_wdata, 0);
        check("mrst_err", err, 0);
        check("mrst_busy", busy, 0);
        check("mrst_no_write", wr_cnt - w0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        $display("txn reset-abort addr=60");

        ready_delay = 0;
        w0 = wr_cnt;
        host_req_phase(1'b1, 8'h01, cyc);
        host_release(cyc);
        host_req_phase(1'b1, 8'h02, cyc);
        check("post_rst_wr_lat", cyc, 4);
        host_release(cyc);
        check("post_rst_wr_mem", mem[8'h01], 8'h02);
        check("post_rst_wr_count", wr_cnt - w0, 1);
        $display("txn write addr=01 data=02");

        // Back-to-back: read 10, write 11<-22, read 11
        host_req_phase(1'b0, 8'h10, cyc);
        check("b2b_rd_lat", cyc, 4);
        check("b2b_rd1", host_rdata, 8'h38);
        host_release(cyc);
        check("b2b_busy1", busy, 0);
        $display("txn read addr=10 rdata=%02h", host_rdata);
        host_req_phase(1'b1, 8'h11, cyc);
        host_release(cyc);
        host_req_phase(1'b1, 8'h22, cyc);
        host_release(cyc);
        check("b2b_busy2", busy, 0);
        $display("txn write addr=11 data=22");
        host_req_phase(1'b0, 8'h11, cyc);
        check("b2b_rd2", host_rdata, 8'h22);
        host_release(cyc);
        check("b2b_busy3", busy, 0);
        $display("txn read addr=11 rdata=%02h", host_rdata);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no_finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/host_bridge.md
# host_bridge

Pin-level register-access responder for the SoC. The external host, or the cocotb bench driving the top-level pins, initiates transactions with a 4-phase req/ack handshake on an 8-bit data bus. `host_bridge` is the responding end: it decodes address and data bytes and issues single-beat valid/ready accesses on the internal SoC register bus. It sits between the top-level pin mux (`ui_in`/`uio_in`/`uo_out`) and the SoC register interconnect.

## Interface
- `TIMEOUT`, 64: max cycles to wait for `bus_ready` before aborting the access; legal range 2..255.
- `ERR_DATA`, 8'hFF: read data returned on a timed-out read.

- `clk`  in  1  single clock; all logic rises on it.
- `rst`  in  1  synchronous, active-high reset.
- `host_req`  in  1  host request; asynchronous to `clk`, synchronized internally.
- `host_we`  in  1  op select, sampled with the address byte (1 = write).
- `host_data`  in  8  address byte or write-data byte from the host.
- `host_ack`  out  1  handshake acknowledge (registered).
- `host_rdata`  out  8  read data; valid while `host_ack`=1 on a read, held until the next read completes.
- `bus_valid`  out  1  internal bus request.
- `bus_we`  out  1  internal bus write enable.
- `bus_addr`  out  8  internal bus address.
- `bus_wdata`  out  8  internal bus write data.
- `bus_ready`  in  1  internal bus completion.
- `bus_rdata`  in  8  internal bus read data; sampled when `bus_valid && bus_ready`.
- `clr_err`  in  1  one-cycle pulse that clears `err`.
- `err`  out  1  sticky timeout flag.
- `busy`  out  1  1 whenever the FSM is not in IDLE.

## Operation
- `host_req` passes through a 2-flop synchronizer to give `req_s`. `host_we` and `host_data` must be stable while `host_req`=1. They are sampled in the same cycle the FSM sees `req_s`=1.
- **Host rule:** raise `host_req` only while `host_ack`=0; hold it until `host_ack`=1, then drop it.
- **IDLE** (ack=0)
  - On `req_s`=1, latch `bus_addr`=`host_data` and `bus_we`=`host_we`.
  - Write goes to ACK_A. Read goes to BUS.
- **ACK_A** (ack=1)
  - On `req_s`=0, go to WAIT_D.
- **WAIT_D** (ack=0)
  - On `req_s`=1, latch `bus_wdata`=`host_data` and go to BUS.
- **BUS** (`bus_valid`=1, ack=0)
  - The timeout counter clears on entry and increments each cycle.
  - On `bus_ready`=1: for a read, capture `host_rdata`=`bus_rdata`; go to ACK_F.
  - Otherwise, when the counter reaches `TIMEOUT`-1: set `err`; for a read, `host_rdata`=`ERR_DATA`; go to ACK_F.
  - If `bus_ready` arrives in the same cycle as the timeout, `bus_ready` wins and `err` is not set.
- **ACK_F** (ack=1)
  - On `req_s`=0, go to IDLE.
- **Transaction shapes**
  - A write is two handshakes (address, then data). The second ack means the write has completed on the bus.
  - A read is one handshake. Its ack means `host_rdata` is valid.
- **Bus outputs:** `bus_addr`, `bus_we` and `bus_wdata` hold their values outside BUS. `bus_valid` is 0 outside BUS.
- **`err`:** set by a timeout, cleared by `clr_err`. If set and clear happen in the same cycle, set wins.

## Timing
- **Reset values:** `host_ack`=0, `host_rdata`=0, `bus_valid`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `err`=0, `busy`=0; FSM=IDLE; synchronizer flops=0.
- **Reset mid-transaction:** reset aborts it. `bus_valid` drops in the cycle after `rst` is sampled, and the host must restart from the address byte.
- **Request latency:** `host_req` rising before edge k gives `req_s`=1 after edge k+1. The FSM transitions at edge k+2, so `host_ack` is visible after edge k+2 for the ACK_A case.
- **Read latency:** with `bus_ready` tied high, `host_ack` rises 4 edges after `host_req` (2 sync, 1 IDLE→BUS, 1 BUS→ACK_F).
- **Release latency:** `host_ack` falls 3 edges after `host_req` falls.
- **Timeout:** BUS lasts at most `TIMEOUT` cycles.
- **Registers:** all outputs are registered; there is no combinational path from pins to outputs.

## Structure
- **Package `host_bridge_pkg`:** FSM state enum (IDLE, ACK_A, WAIT_D, BUS, ACK_F), default `TIMEOUT`, `ERR_DATA`.
- **Sub-module `host_bridge_sync`:** parameterized-width 2-flop synchronizer with reset to 0, used for `host_req`.
- **Counter:** the timeout counter is `$clog2(TIMEOUT)` bits wide and lives inline in `host_bridge`.

## Test plan
- **Write:** handshake addr 8'h12 with we=1, then data 8'hA5; `bus_ready` tied high → exactly one bus write with addr 12/wdata A5. Second ack follows bus completion; `err`=0.
- **Read:** addr 8'h34 with we=0; bus returns 8'h5C after 3 wait cycles → `host_rdata`=5C while ack=1 and held afterwards. `bus_valid` is high for exactly 4 cycles.
- **Timeout:** read addr 8'h40 with `bus_ready` held 0 and `TIMEOUT`=64 → BUS lasts 64 cycles, `host_rdata`=FF, `err`=1. A `clr_err` pulse → `err`=0.
- **Ready/timeout collision:** `bus_ready` asserted in cycle 63 of BUS → `err` stays 0 and `host_rdata` takes `bus_rdata`.
- **Mid-transaction reset:** `rst` asserted during BUS of a write → all outputs return to reset values the next cycle. A fresh write 8'h01/8'h02 then completes normally.
- **Back-to-back:** read 8'h10, write 8'h11/8'h22, read 8'h11 → the second read returns the value the bus model stored (8'h22). `busy` drops between transactions.
